// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling and stop-period constants,
// and the parity helper used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE = 16;

  localparam int STOP_1   = 16;
  localparam int STOP_1_5 = 24;
  localparam int STOP_2   = 32;

  // Unused upper bits must be zero so they do not disturb the reduction.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: s_tick pulses once every DVSR cycles while clr is low,
// with the phase restarting from zero whenever clr is high.
module uart_baud_tick #(
  parameter int DVSR = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic s_tick,
  output logic s_tick_next
);

  localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(DVSR - 1);

  logic [BW-1:0] b_q;
  logic [BW-1:0] b_d;

  always_comb begin
    b_d = b_q;
    if (clr) begin
      b_d = {BW{1'b0}};
    end else if (b_q == B_LAST) begin
      b_d = {BW{1'b0}};
    end else begin
      b_d = b_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_q <= {BW{1'b0}};
    end else begin
      b_q <= b_d;
    end
  end

  assign s_tick = ~clr & (b_q == B_LAST);
  // Lets a client register an output that has to coincide with the coming tick.
  assign s_tick_next = (b_d == B_LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period.
// tx, tx_busy and tx_done_tick are all driven straight from flops.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR       = 27,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DBIT - 1);
  localparam logic [5:0]    TICK_LAST = 6'(OVERSAMPLE - 1);
  localparam logic [5:0]    STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [5:0]    STOP_PRE  = 6'(SB_TICK - 2);

  uart_state_t     state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic clr_s;
  logic s_tick_s;
  logic s_tick_next_s;

  assign clr_s = (state_q == IDLE);

  uart_baud_tick #(
    .DVSR(DVSR)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr_s),
    .s_tick     (s_tick_s),
    .s_tick_next(s_tick_next_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shreg_d = din;
          par_d   = parity_bit(9'(din), (PARITY_ODD != 0));
          tick_d  = 6'd0;
          idx_d   = {IW{1'b0}};
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (s_tick_s) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 6'd0;
            idx_d   = {IW{1'b0}};
            state_d = DATA;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      DATA: begin
        if (s_tick_s) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 6'd0;
            shreg_d = shreg_q >> 1;
            if (idx_q == IDX_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      PARITY: begin
        if (s_tick_s) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 6'd0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      STOP: begin
        if (s_tick_s) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = 6'd0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end else begin
          tick_d = tick_q;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = 6'd0;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Outputs are computed from the next state so the flops line up with the frame.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    // The done flop is loaded one cycle early so it is high during the final stop cycle.
    if (state_q == STOP) begin
      if (s_tick_s) begin
        done_d = s_tick_next_s && (tick_q == STOP_PRE);
      end else begin
        done_d = s_tick_next_s && (tick_q == STOP_LAST);
      end
    end else begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= 6'd0;
      idx_q   <= {IW{1'b0}};
      shreg_q <= {DBIT{1'b0}};
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Bench for uart_tx_unit: five parameterisations driven by shared stimulus, each checked
// every cycle against a frame-offset model, plus decoded-frame checks with fixed values.
module tb_uart_tx_unit;

  localparam int ND = 5;
  localparam int C_DBIT [ND] = '{8, 8, 7, 8, 8};
  localparam int C_SB   [ND] = '{16, 16, 32, 16, 24};
  localparam int C_DVSR [ND] = '{4, 4, 4, 1, 2};
  localparam int C_PEN  [ND] = '{0, 1, 0, 0, 1};
  localparam int C_PODD [ND] = '{0, 0, 0, 0, 1};

  logic          clk        = 1'b0;
  logic          reset_s    = 1'b1;
  logic          tx_start_s = 1'b0;
  logic [8:0]    din_s      = 9'h000;
  logic [ND-1:0] tx_w;
  logic [ND-1:0] busy_w;
  logic [ND-1:0] done_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    uart_tx_unit #(
      .DBIT      (C_DBIT[g]),
      .SB_TICK   (C_SB[g]),
      .DVSR      (C_DVSR[g]),
      .PARITY_EN (C_PEN[g]),
      .PARITY_ODD(C_PODD[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset_s),
      .tx_start    (tx_start_s),
      .din         (din_s[C_DBIT[g]-1:0]),
      .tx_busy     (busy_w[g]),
      .tx_done_tick(done_w[g]),
      .tx          (tx_w[g])
    );
  end

  int n_chk_m  = 0;
  int n_fail_m = 0;
  int n_chk_d  = 0;
  int n_fail_d = 0;
  bit mon_en   = 1'b0;

  // Model: a frame is just "k cycles since the line fell" plus the byte latched at accept.
  logic [ND-1:0] m_act = '0;
  int            m_k    [ND];
  logic [8:0]    m_byte [ND];

  function automatic int flen(input int d);
    return (1 + C_DBIT[d] + C_PEN[d]) * 16 * C_DVSR[d] + C_SB[d] * C_DVSR[d];
  endfunction

  function automatic logic par_of(input int d, input logic [8:0] b);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < C_DBIT[d]; i++) ones += int'(b[i]);
    p = ((ones % 2) == 1);
    if (C_PODD[d] != 0) p = ~p;
    return p;
  endfunction

  function automatic logic exp_tx(input int d, input logic [8:0] b, input int k);
    int slot;
    slot = k / (16 * C_DVSR[d]);
    if (slot == 0) return 1'b0;
    if (slot <= C_DBIT[d]) return b[slot-1];
    if (C_PEN[d] != 0 && slot == C_DBIT[d] + 1) return par_of(d, b);
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset_s) begin
        m_act[d] <= 1'b0;
      end else if (!m_act[d]) begin
        if (tx_start_s) begin
          m_act[d]  <= 1'b1;
          m_k[d]    <= 0;
          m_byte[d] <= din_s;
        end
      end else begin
        m_k[d] <= m_k[d] + 1;
        if (m_k[d] + 1 == flen(d)) m_act[d] <= 1'b0;
      end
    end
  end

  logic e_tx, e_busy, e_done;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        e_busy = m_act[d];
        e_tx   = m_act[d] ? exp_tx(d, m_byte[d], m_k[d]) : 1'b1;
        e_done = m_act[d] && (m_k[d] == flen(d) - 1);
        n_chk_m++;
        if (tx_w[d] !== e_tx) begin
          n_fail_m++;
          $display("FAIL tx dut%0d k=%0d: got %b expected %b", d, m_k[d], tx_w[d], e_tx);
        end
        n_chk_m++;
        if (busy_w[d] !== e_busy) begin
          n_fail_m++;
          $display("FAIL busy dut%0d k=%0d: got %b expected %b", d, m_k[d], busy_w[d], e_busy);
        end
        n_chk_m++;
        if (done_w[d] !== e_done) begin
          n_fail_m++;
          $display("FAIL done dut%0d k=%0d: got %b expected %b", d, m_k[d], done_w[d], e_done);
        end
      end
    end
  end

  logic [8:0] rx_data [ND];
  logic       rx_par  [ND];
  int         rx_len  [ND];
  int         rx_low  [ND];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk_d++;
    if (act !== exp) begin
      n_fail_d++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Simple receiver: samples mid-bit from the first start cycle until tx_done_tick.
  task automatic rx_frame(input int d, output logic [8:0] data, output logic pbit,
                          output int len, output int lows);
    int bl;
    int slot;
    bl   = 16 * C_DVSR[d];
    data = 9'h000;
    pbit = 1'b0;
    len  = 0;
    lows = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx_w[d] == 1'b0) lows++;
      if ((k % bl) == (bl / 2)) begin
        slot = k / bl;
        if (slot >= 1 && slot <= C_DBIT[d]) data[slot-1] = tx_w[d];
        else if (C_PEN[d] != 0 && slot == C_DBIT[d] + 1) pbit = tx_w[d];
      end
      if (done_w[d]) begin
        len = k + 1;
        break;
      end
    end
  endtask

  task automatic send_and_receive(input logic [8:0] b);
    @(negedge clk);
    din_s      = b;
    tx_start_s = 1'b1;
    @(posedge clk);
    #1;
    tx_start_s = 1'b0;
    fork
      rx_frame(0, rx_data[0], rx_par[0], rx_len[0], rx_low[0]);
      rx_frame(1, rx_data[1], rx_par[1], rx_len[1], rx_low[1]);
      rx_frame(2, rx_data[2], rx_par[2], rx_len[2], rx_low[2]);
      rx_frame(3, rx_data[3], rx_par[3], rx_len[3], rx_low[3]);
      rx_frame(4, rx_data[4], rx_par[4], rx_len[4], rx_low[4]);
    join
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
    check("reset_tx", 32'(tx_w), 32'h1F);
    check("reset_busy", 32'(busy_w), 32'h0);
    check("reset_done", 32'(done_w), 32'h0);
    reset_s = 1'b0;
    repeat (3) @(negedge clk);

    send_and_receive(9'h0A5);
    check("a5_8n1_data", 32'(rx_data[0]), 32'h0A5);
    check("a5_8n1_len", 32'(rx_len[0]), 32'd640);
    check("a5_8n1_low_cycles", 32'(rx_low[0]), 32'd320);
    check("a5_even_par", 32'(rx_par[1]), 32'd0);
    check("a5_even_len", 32'(rx_len[1]), 32'd704);
    check("a5_7bit_data", 32'(rx_data[2]), 32'h025);
    check("a5_dvsr1_len", 32'(rx_len[3]), 32'd160);
    check("a5_odd_par", 32'(rx_par[4]), 32'd1);
    check("a5_odd_len", 32'(rx_len[4]), 32'd368);

    send_and_receive(9'h001);
    check("01_even_par", 32'(rx_par[1]), 32'd1);
    check("01_odd_par", 32'(rx_par[4]), 32'd0);

    send_and_receive(9'h000);
    check("00_dvsr1_low_cycles", 32'(rx_low[3]), 32'd144);
    check("00_dvsr1_len", 32'(rx_len[3]), 32'd160);

    send_and_receive(9'h07F);
    check("7f_7bit_data", 32'(rx_data[2]), 32'h07F);
    check("7f_7bit_2stop_len", 32'(rx_len[2]), 32'd640);
    check("7f_7bit_low_cycles", 32'(rx_low[2]), 32'd64);

    // Abort dut0 inside data bit 3, then confirm a clean frame afterwards.
    @(negedge clk);
    din_s      = 9'h03C;
    tx_start_s = 1'b1;
    @(posedge clk);
    #1;
    tx_start_s = 1'b0;
    repeat (4 * 64 + 20) @(negedge clk);
    reset_s = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx_w), 32'h1F);
    check("abort_busy", 32'(busy_w), 32'h0);
    check("abort_done", 32'(done_w), 32'h0);
    reset_s = 1'b0;
    repeat (5) @(negedge clk);
    send_and_receive(9'h03C);
    check("3c_after_abort_data", 32'(rx_data[0]), 32'h03C);
    check("3c_after_abort_len", 32'(rx_len[0]), 32'd640);

    // Continuous request with din toggling every cycle.
    tx_start_s = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      din_s = c[0] ? 9'h055 : 9'h0AA;
    end
    tx_start_s = 1'b0;
    repeat (800) @(negedge clk);

    // Random requests, data and occasional resets.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      tx_start_s = ($urandom_range(0, 3) == 0);
      din_s      = 9'($urandom_range(0, 511));
      reset_s    = ($urandom_range(0, 1999) == 0);
    end
    tx_start_s = 1'b0;
    reset_s    = 1'b0;
    repeat (800) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk_m + n_chk_d, n_fail_m + n_fail_d);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
# uart_tx_unit

Serial UART transmitter. Serializes one parallel byte per `tx_start` handshake onto the `tx` line: start bit, DBIT data bits LSB first, optional parity bit, and a stop period. It sits on the write side of the `uart` block, fed from the TX FIFO (`tx_start` = FIFO not empty, `din` = FIFO head). It pairs with the existing receiver on the opposite end of the link and uses the same 16× oversampling convention as that receiver.

## Interface
Parameters:
- `DBIT`, 8: number of data bits; legal range 5–9.
- `SB_TICK`, 16: stop period in oversample ticks; 16, 24 and 32 give 1, 1.5 and 2 stop bits.
- `DVSR`, 27: clock cycles per oversample tick; must be ≥ 1 (163 gives 19200 baud at 50 MHz).
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.

Ports:
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `tx_start` in 1: request to send `din`; sampled only in IDLE.
- `din` in DBIT: byte to send; latched in the accept cycle.
- `tx_busy` out 1: high while a frame is in progress.
- `tx_done_tick` out 1: one-cycle pulse at the end of the stop period.
- `tx` out 1: serial line, registered, idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Baud counter `b` counts 0..DVSR-1 and pulses `s_tick` when `b`=DVSR-1. It is held at 0 in IDLE, so every bit lasts exactly 16·DVSR cycles with no phase jitter.
- IDLE: `tx`=1, `tx_busy`=0. On `tx_start`=1: latch `din` into a shift register, compute the parity bit, and go to START. `tx_start` in any other state is ignored; the data is not queued.
- START: `tx`=0 for 16 ticks, then go to DATA with bit index 0.
- DATA: `tx`=shreg[0] for 16 ticks, then shift right and increment the index. After bit DBIT-1, go to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: `tx`=^data for even parity, ~^data for odd, held for 16 ticks. Parity is computed on the latched byte.
- STOP: `tx`=1 for SB_TICK ticks. On the last tick, pulse `tx_done_tick` and go to IDLE.
- Counter widths:
  - tick counter: 6 bits, covering SB_TICK up to 32;
  - bit index: $clog2(DBIT) bits;
  - baud counter: $clog2(DVSR) bits, minimum 1.
- Reset mid-frame aborts the frame: `tx`=1 on the next cycle, state IDLE, no `tx_done_tick`.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done_tick`=0, FSM=IDLE, all counters 0.
- Accept: `tx_start` is high in IDLE at edge N. Then `tx`=0 and `tx_busy`=1 from N+1. This is one cycle of latency.
- Frame length, from the `tx` falling edge to the cycle `tx_done_tick` is high inclusive: (1+DBIT+PARITY_EN)·16·DVSR + SB_TICK·DVSR cycles.
- End of frame: `tx_done_tick` is high for exactly one cycle, the last stop cycle. `tx_busy` drops the following cycle.
- Back-to-back frames: if `tx_start` is high in the first IDLE cycle after `tx_done_tick`, the next start bit begins one cycle later. The inter-frame gap is therefore the stop period plus one idle cycle, at most.
- `din` changes after the accept edge do not affect the frame in flight.
- DVSR=1 is legal: `s_tick` is high every cycle.

## Structure
- Shared `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, PARITY, STOP};
  - constant `OVERSAMPLE`=16;
  - stop-tick constants `STOP_1`=16, `STOP_1_5`=24, `STOP_2`=32.
  - The receiver uses the same package.
- One sub-module, `uart_baud_tick` (parameter DVSR; ports `clk`, `reset`, `clr`, `s_tick`):
  - the transmitter drives `clr` high in IDLE;
  - the module is reusable by the receiver.
- All outputs are registered; there is no combinational path from `tx_start` to `tx`.

## Test plan
- 8N1, DVSR=4, send 0xA5:
  - `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 cycles;
  - `tx_done_tick` exactly 640 cycles after the falling edge inclusive;
  - receiver model decodes 0xA5.
- PARITY_EN=1: send 0xA5 (four ones).
  - Even parity: parity bit 0. Odd parity: parity bit 1.
  - Send 0x01: even parity bit 1.
  - Frame length 704 cycles at DVSR=4.
- SB_TICK=32, DBIT=7, send 0x7F: stop high for 128 cycles; frame = 8·64+128 = 640 cycles.
- `tx_start` held high continuously with `din` toggling between 0x55 and 0xAA:
  - frames are contiguous with ≤1 idle cycle between them;
  - `din` changes mid-frame do not corrupt the frame in flight;
  - `tx_start` pulses during a frame are ignored.
- Assert `reset` during DATA bit 3:
  - next cycle `tx`=1, `tx_busy`=0, no `tx_done_tick`;
  - a subsequent send of 0x3C is correct.
- DVSR=1, send 0x00: each bit is 16 cycles; `tx` is low for 144 cycles (start plus 8 data bits), then high for 16 cycles.
